// File: rtl/servo_pwm_gen.sv
// Servo PWM frame generator: fixed-period frame with a clamped, frame-synchronous pulse width.
// Optional macro SERVO_SLEW_EN limits the per-frame width change to SLEW_STEP.
//
// Ports:
//   CLK         system clock
//   RST         synchronous active-high reset
//   EN          run request (1 = generate frames)
//   temPWM      requested pulse width in CLK cycles
//   pwm_out     registered servo control line
//   frame_start one-cycle strobe on the first cycle of each frame
//   width_out   pulse width currently in effect
//   clamped     loaded request of the current frame was out of range
module servo_pwm_gen #(
   parameter int PERIOD    = 1000000,
   parameter int MIN_W     = 25000,
   parameter int MAX_W     = 125000,
   parameter int SLEW_STEP = 500
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        EN,
   input  logic [16:0] temPWM,
   output logic        pwm_out,
   output logic        frame_start,
   output logic [16:0] width_out,
   output logic        clamped
);

   localparam int CW = $clog2(PERIOD);
   localparam int XW = (CW > 17) ? CW : 17;
   localparam logic [CW-1:0] LAST  = CW'(PERIOD - 1);
   localparam logic [16:0]   MIN_V = 17'(MIN_W);
   localparam logic [16:0]   MAX_V = 17'(MAX_W);

   typedef enum logic {IDLE, RUN} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [16:0]   shadow_q, shadow_d;
   logic          clamped_q, clamped_d;
   logic          pwm_q, pwm_d;
   logic          fs_q, fs_d;

   logic          too_lo, too_hi, load;
   logic [16:0]   target, load_w;

   // Width that would be loaded at a frame boundary
   always_comb begin
      too_lo = temPWM < MIN_V;
      too_hi = temPWM > MAX_V;
      target = too_lo ? MIN_V : (too_hi ? MAX_V : temPWM);
`ifdef SERVO_SLEW_EN
      if (target > shadow_q) begin
         load_w = ((target - shadow_q) > 17'(SLEW_STEP))
                  ? shadow_q + 17'(SLEW_STEP) : target;
      end else begin
         load_w = ((shadow_q - target) > 17'(SLEW_STEP))
                  ? shadow_q - 17'(SLEW_STEP) : target;
      end
`else
      load_w = target;
`endif
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      shadow_d  = shadow_q;
      clamped_d = clamped_q;
      load      = 1'b0;
      unique case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (EN) begin
               state_d = RUN;
               load    = 1'b1;
            end
         end
         RUN: begin
            if (cnt_q == LAST) begin
               cnt_d = '0;
               if (EN) load = 1'b1;
               else    state_d = IDLE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
      if (load) begin
         shadow_d  = load_w;
         clamped_d = too_lo | too_hi;
      end
      fs_d  = load;
      // Pulse is derived from next-state values so it is aligned
      // with the registered counter and starts in the frame_start cycle
      pwm_d = (state_d == RUN) && (XW'(cnt_d) < XW'(shadow_d));
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         shadow_q  <= MIN_V;
         clamped_q <= 1'b0;
         pwm_q     <= 1'b0;
         fs_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         shadow_q  <= shadow_d;
         clamped_q <= clamped_d;
         pwm_q     <= pwm_d;
         fs_q      <= fs_d;
      end
   end

   assign pwm_out     = pwm_q;
   assign frame_start = fs_q;
   assign width_out   = shadow_q;
   assign clamped     = clamped_q;

endmodule

// File: tb/tb_servo_pwm_gen.sv
// Self-checking bench for servo_pwm_gen with reduced frame parameters.
// Table-driven width/clamp vectors plus hand sequences for stop, reset and slew.
module tb_servo_pwm_gen;

   localparam int PERIOD = 1000;
   localparam int MIN_W  = 25;
   localparam int MAX_W  = 125;
   localparam int STEP   = 10;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        EN = 1'b0;
   logic [16:0] temPWM = 17'd0;
   logic        pwm_out, frame_start, clamped;
   logic [16:0] width_out;

   int n_chk = 0;
   int n_pass = 0;

   servo_pwm_gen #(
      .PERIOD(PERIOD), .MIN_W(MIN_W), .MAX_W(MAX_W), .SLEW_STEP(STEP)
   ) dut (
      .CLK(CLK), .RST(RST), .EN(EN), .temPWM(temPWM),
      .pwm_out(pwm_out), .frame_start(frame_start),
      .width_out(width_out), .clamped(clamped)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      int req;
      int exp_w;
      bit exp_c;
   } vec_t;

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic check(input string name, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   function automatic int slew(input int prev, input int tgt);
`ifdef SERVO_SLEW_EN
      if (tgt > prev + STEP) return prev + STEP;
      if (tgt < prev - STEP) return prev - STEP;
      return tgt;
`else
      return tgt;
`endif
   endfunction

   // Runs from a frame_start cycle to the next one (bounded), changing
   // the request at cycle chg_at of the frame.
   task automatic run_frame(input int nreq, input int chg_at,
                            output int hi, output int len);
      hi  = 0;
      len = 0;
      do begin
         if (pwm_out) hi++;
         len++;
         if (len == chg_at) temPWM = 17'(nreq);
         tick();
      end while (!frame_start && len < 1100);
   endtask

   vec_t vecs[9];
   int   cur, hi, len, fs_cnt, exp_w;

   initial begin
      vecs[0] = '{125, 125, 0};
      vecs[1] = '{25,  25,  0};
      vecs[2] = '{125, 125, 0};
      vecs[3] = '{10,  25,  1};
      vecs[4] = '{200, 125, 1};
      vecs[5] = '{24,  25,  1};
      vecs[6] = '{126, 125, 1};
      vecs[7] = '{100, 100, 0};
      vecs[8] = '{0,   25,  1};

      repeat (3) tick();
      check("rst_pwm", int'(pwm_out), 0);
      check("rst_fs", int'(frame_start), 0);
      check("rst_width", int'(width_out), MIN_W);
      check("rst_clamped", int'(clamped), 0);

      temPWM = 17'd125;
      EN  = 1'b1;
      RST = 1'b0;
      tick();
      check("start_fs", int'(frame_start), 1);
      check("start_pwm", int'(pwm_out), 1);
      cur = slew(MIN_W, 125);
      check("start_width", int'(width_out), cur);
      check("start_clamped", int'(clamped), 0);

      for (int i = 0; i < 9; i++) begin
         run_frame(vecs[i].req, 61, hi, len);
         check("vec_len", len, PERIOD);
         check("vec_pulse", hi, cur);
         cur = slew(cur, vecs[i].exp_w);
         check("vec_width", int'(width_out), cur);
         check("vec_clamped", int'(clamped), int'(vecs[i].exp_c));
      end

      run_frame(125, 61, hi, len);
      check("pre_stop_pulse", hi, cur);
      cur = slew(cur, 125);

      // EN dropped mid-frame: full pulse, frame completes, then idle
      hi = 0;
      for (int k = 0; k < PERIOD; k++) begin
         if (pwm_out) hi++;
         if (k == 40) EN = 1'b0;
         tick();
      end
      check("stop_pulse", hi, cur);
      check("stop_fs", int'(frame_start), 0);
      fs_cnt = 0;
      hi = 0;
      for (int k = 0; k < 1200; k++) begin
         if (frame_start) fs_cnt++;
         if (pwm_out) hi++;
         tick();
      end
      check("idle_fs_count", fs_cnt, 0);
      check("idle_pwm_count", hi, 0);
      check("idle_width_kept", int'(width_out), cur);

      // Restart, then cancel a stop by re-asserting EN mid-frame
      EN = 1'b1;
      tick();
      check("restart_fs", int'(frame_start), 1);
      cur = slew(cur, 125);
      for (int k = 0; k < PERIOD; k++) begin
         if (k == 40)  EN = 1'b0;
         if (k == 500) EN = 1'b1;
         tick();
      end
      check("cancel_fs", int'(frame_start), 1);
      cur = slew(cur, 125);

      // Reset mid-pulse
      repeat (50) tick();
      check("pre_rst_pwm", int'(pwm_out), 1);
      RST = 1'b1;
      tick();
      check("midrst_pwm", int'(pwm_out), 0);
      check("midrst_width", int'(width_out), MIN_W);
      check("midrst_fs", int'(frame_start), 0);
      RST = 1'b0;
      tick();
      check("postrst_fs", int'(frame_start), 1);
      check("postrst_pwm", int'(pwm_out), 1);

      // Ramp from MIN_W toward 125 (slewed or immediate)
      for (int f = 0; f < 10; f++) begin
`ifdef SERVO_SLEW_EN
         exp_w = 35 + 10 * f;
`else
         exp_w = 125;
`endif
         check("ramp_width", int'(width_out), exp_w);
         run_frame((f == 9) ? 120 : 125, 61, hi, len);
         check("ramp_pulse", hi, exp_w);
      end
      check("final_width", int'(width_out), 120);
      run_frame(120, 61, hi, len);
      check("final_pulse", hi, 120);
      check("final_len", len, PERIOD);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
